// File: rtl/polar_tx_scheduler.sv
// rtl/polar_tx_scheduler.sv - ping-pong codeword buffer feeding an LSB-first serializer with SOF/EOF and inter-frame gap
module polar_tx_scheduler #(
    parameter int N          = 1024,
    parameter int LOG2N      = 10,
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cw_valid,
    input  logic [N-1:0] cw_data,
    output logic         cw_ready,
    input  logic         ser_ready,
    output logic         ser_valid,
    output logic         ser_data,
    output logic         ser_sof,
    output logic         ser_eof,
    output logic         busy,
    output logic [15:0]  frames_sent
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [LOG2N-1:0] LAST_BIT = LOG2N'(N - 1);
    localparam logic [7:0]       GAP_INIT = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t             state, state_next;
    logic [N-1:0]       slot [2];
    logic [1:0]         count;
    logic               wr_sel, rd_sel;
    logic [N-1:0]       shreg;
    logic [LOG2N-1:0]   bit_cnt;
    logic [7:0]         gap_cnt;
    logic               accept, load, beat, last_beat;

    assign cw_ready  = (count != 2'd2);
    assign accept    = cw_valid && cw_ready;
    assign load      = (state == IDLE) && (count != 2'd0);
    assign beat      = (state == SHIFT) && ser_ready;
    assign last_beat = beat && (bit_cnt == LAST_BIT);

    assign ser_valid = (state == SHIFT);
    assign ser_data  = shreg[0];
    assign ser_sof   = ser_valid && (bit_cnt == '0);
    assign ser_eof   = ser_valid && (bit_cnt == LAST_BIT);
    assign busy      = (state != IDLE) || (count != 2'd0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (last_beat) state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == 8'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Slot storage carries no reset: contents are only read after being written.
    always_ff @(posedge clk) begin
        if (accept) slot[wr_sel] <= cw_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= 2'd0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= 8'd0;
            frames_sent <= 16'd0;
        end else begin
            if (accept) wr_sel <= ~wr_sel;
            case ({accept, load})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (load) begin
                shreg   <= slot[rd_sel];
                rd_sel  <= ~rd_sel;
                bit_cnt <= '0;
            end else if (beat) begin
                shreg <= shreg >> 1;
                if (last_beat) begin
                    bit_cnt     <= '0;
                    frames_sent <= frames_sent + 16'd1;
                    gap_cnt     <= GAP_INIT;
                end else begin
                    bit_cnt <= bit_cnt + LOG2N'(1);
                end
            end

            if (state == GAP && gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_polar_tx_scheduler.sv
// tb/tb_polar_tx_scheduler.sv - scoreboard bench for polar_tx_scheduler at N=8 (GAP=2 and GAP=0 instances)
module tb_polar_tx_scheduler;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cw_valid = 1'b0, ser_ready = 1'b1;
    logic [7:0]  cw_data = 8'h00;
    logic        cw_ready, ser_valid, ser_data, ser_sof, ser_eof, busy;
    logic [15:0] frames_sent;
    logic        b_cw_valid = 1'b0, b_ser_ready = 1'b1;
    logic [7:0]  b_cw_data = 8'h00;
    logic        b_cw_ready, b_ser_valid, b_ser_data, b_ser_sof, b_ser_eof, b_busy;
    logic [15:0] b_frames_sent;

    int n_vec = 0, n_err = 0, cyc = 0;
    logic [7:0] sb [$];
    logic [7:0] cur;
    int bidx = 0, in_frame = 0, sof_cyc = 0, prev_sof = 0, have_prev = 0;
    int spacing_exp = 0, stall_exp = 0;
    int b_prev_sof = 0, b_prev_eof = 0, b_have_sof = 0, b_have_eof = 0;

    polar_tx_scheduler #(.N(N), .LOG2N(3), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .cw_valid(cw_valid), .cw_data(cw_data), .cw_ready(cw_ready),
        .ser_ready(ser_ready), .ser_valid(ser_valid), .ser_data(ser_data), .ser_sof(ser_sof),
        .ser_eof(ser_eof), .busy(busy), .frames_sent(frames_sent));

    polar_tx_scheduler #(.N(N), .LOG2N(3), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .cw_valid(b_cw_valid), .cw_data(b_cw_data), .cw_ready(b_cw_ready),
        .ser_ready(b_ser_ready), .ser_valid(b_ser_valid), .ser_data(b_ser_data), .ser_sof(b_ser_sof),
        .ser_eof(b_ser_eof), .busy(b_busy), .frames_sent(b_frames_sent));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard for instance A: accepted words are queued, every presented bit is compared.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            in_frame = 0;
        end else begin
            if (cw_valid && cw_ready) sb.push_back(cw_data);
            if (ser_valid) begin
                if (in_frame == 0) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_underflow", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        in_frame = 1;
                        bidx = 0;
                        sof_cyc = cyc;
                        if (spacing_exp != 0 && have_prev != 0)
                            check_eq("sof_spacing", cyc - prev_sof, spacing_exp);
                        prev_sof = cyc;
                        have_prev = 1;
                    end
                end
                if (in_frame != 0) begin
                    check_eq("sof", ser_sof, bidx == 0);
                    check_eq("eof", ser_eof, bidx == N - 1);
                    check_eq("data", ser_data, cur[bidx]);
                    if (ser_ready) begin
                        if (bidx == N - 1) begin
                            in_frame = 0;
                            check_eq("frame_len", cyc - sof_cyc, N - 1 + stall_exp);
                        end else begin
                            bidx++;
                        end
                    end
                end
            end
        end
    end

    // Instance B (no gap): SOF-to-SOF and EOF-to-SOF spacing.
    always @(negedge clk) begin
        if (reset && b_ser_valid && b_ser_ready) begin
            if (b_ser_sof) begin
                if (b_have_sof != 0) check_eq("b_sof_spacing", cyc - b_prev_sof, N + 1);
                if (b_have_eof != 0) check_eq("b_eof_to_sof", cyc - b_prev_eof, 2);
                b_prev_sof = cyc;
                b_have_sof = 1;
            end
            if (b_ser_eof) begin
                b_prev_eof = cyc;
                b_have_eof = 1;
            end
        end
    end

    task automatic send_word(input logic [7:0] w);
        int t = 0;
        cw_valid = 1'b1;
        cw_data  = w;
        @(negedge clk);
        while (!cw_ready && t < 100) begin @(negedge clk); t++; end
        if (!cw_ready) check_eq("send_timeout", 0, 1);
        @(posedge clk); #2;
    endtask

    task automatic send_word_b(input logic [7:0] w);
        int t = 0;
        b_cw_valid = 1'b1;
        b_cw_data  = w;
        @(negedge clk);
        while (!b_cw_ready && t < 100) begin @(negedge clk); t++; end
        if (!b_cw_ready) check_eq("send_b_timeout", 0, 1);
        @(posedge clk); #2;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 300) begin @(negedge clk); t++; end
        if (busy) check_eq("idle_timeout", 0, 1);
        @(posedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_ser_valid", ser_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frames", frames_sent, 0);
        reset = 1'b1;
        @(posedge clk); #2;
        check_eq("rst_cw_ready", cw_ready, 1);

        // single frame with latency
        send_word(8'hA5);
        cw_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_pre_valid", ser_valid, 0);
        check_eq("lat_pre_busy", busy, 1);
        @(negedge clk);
        check_eq("lat_valid", ser_valid, 1);
        check_eq("lat_sof", ser_sof, 1);
        @(posedge clk); #2;
        wait_idle();
        check_eq("t2_frames", frames_sent, 1);

        // back-pressure, four continuous codewords
        have_prev = 0;
        spacing_exp = N + 2 + 1;
        send_word(8'h11);
        send_word(8'hE7);
        send_word(8'h3C);
        @(negedge clk);
        check_eq("bp_ready_low", cw_ready, 0);
        @(posedge clk); #2;
        send_word(8'h96);
        cw_valid = 1'b0;
        wait_idle();
        spacing_exp = 0;
        check_eq("t3_frames", frames_sent, 5);
        check_eq("t3_sb_empty", sb.size(), 0);

        // downstream stall at bit 3
        stall_exp = 5;
        send_word(8'h6B);
        cw_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        ser_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        ser_ready = 1'b1;
        wait_idle();
        stall_exp = 0;
        check_eq("t4_frames", frames_sent, 6);

        // frames_sent wrap
        force dut_a.frames_sent = 16'hFFFF;
        @(negedge clk);
        release dut_a.frames_sent;
        @(posedge clk); #2;
        check_eq("wrap_preload", frames_sent, 16'hFFFF);
        send_word(8'hC0);
        cw_valid = 1'b0;
        wait_idle();
        check_eq("wrap_frames", frames_sent, 0);

        // asynchronous reset mid-frame
        send_word(8'hFF);
        send_word(8'h81);
        cw_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("t1_ser_valid", ser_valid, 0);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_frames", frames_sent, 0);
        check_eq("t1_sof", ser_sof, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("t1_quiet", ser_valid, 0);
        end
        @(posedge clk); #2;

        // zero gap on instance B
        send_word_b(8'h5A);
        send_word_b(8'hC3);
        send_word_b(8'h0F);
        b_cw_valid = 1'b0;
        for (int t = 0; t < 300 && (b_busy || b_frames_sent != 3); t++) @(negedge clk);
        check_eq("t5_frames", b_frames_sent, 3);
        check_eq("t5_busy", b_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
